// File: rtl/clap_sequence_detector.sv
// rtl/clap_sequence_detector.sv - clap envelope recogniser and clap-sequence counter
//
// Classifies each accepted energy sample as high (H), mid (M) or low (L),
// recognises the H-run / optional M-decay / L-tail envelope of a clap and
// counts consecutive claps. The count is emitted when the inter-clap gap
// times out or when MAX_CLAPS is reached (claps_out_full=1).
//
// Optional feature macro: CLAP_REFRACTORY_EN
//   defined   - REFRACTORY_SAMPLES accepted samples after each clap hold the FSM in IDLE
//   undefined - no blanking, REFRACTORY_SAMPLES has no effect
//
// Ports:
//   clock            rising-edge clock
//   counters_nreset  asynchronous active-low reset
//   energy_data      energy sample
//   energy_valid     sample valid
//   energy_ready     sample ready, low while a result is pending
//   claps_out_data   number of claps in the closed sequence
//   claps_out_full   emit was forced by reaching MAX_CLAPS
//   claps_out_valid  result valid
//   claps_out_ready  result accepted
module clap_sequence_detector #(
  parameter int ENERGY_WIDTH          = 16,
  parameter int ENERGY_HIGH_THRESHOLD = 100,
  parameter int ENERGY_LOW_THRESHOLD  = 50,
  parameter int SAMPLE_HIGH_MIN       = 4,
  parameter int SAMPLE_MID_MAX        = 10,
  parameter int SAMPLE_LOW_MIN        = 200,
  parameter int CLAPS_GAP_SAMPLES     = 2000,
  parameter int MAX_CLAPS             = 8,
  parameter int CLAPS_OUT_WIDTH       = 4,
  parameter int REFRACTORY_SAMPLES    = 100
) (
  input  logic                       clock,
  input  logic                       counters_nreset,
  input  logic [ENERGY_WIDTH-1:0]    energy_data,
  input  logic                       energy_valid,
  output logic                       energy_ready,
  output logic [CLAPS_OUT_WIDTH-1:0] claps_out_data,
  output logic                       claps_out_full,
  output logic                       claps_out_valid,
  input  logic                       claps_out_ready
);

  localparam int RUN_CFG_MAX =
    (SAMPLE_LOW_MIN > SAMPLE_MID_MAX)
      ? ((SAMPLE_LOW_MIN > SAMPLE_HIGH_MIN) ? SAMPLE_LOW_MIN : SAMPLE_HIGH_MIN)
      : ((SAMPLE_MID_MAX > SAMPLE_HIGH_MIN) ? SAMPLE_MID_MAX : SAMPLE_HIGH_MIN);
  localparam int RUN_W = $clog2(RUN_CFG_MAX + 1);
  localparam int GAP_W = $clog2(CLAPS_GAP_SAMPLES + 1);

  localparam logic [ENERGY_WIDTH-1:0]    HIGH_T     = ENERGY_WIDTH'(ENERGY_HIGH_THRESHOLD);
  localparam logic [ENERGY_WIDTH-1:0]    LOW_T      = ENERGY_WIDTH'(ENERGY_LOW_THRESHOLD);
  localparam logic [RUN_W-1:0]           HIGH_MIN_R = RUN_W'(SAMPLE_HIGH_MIN);
  localparam logic [RUN_W-1:0]           MID_MAX_R  = RUN_W'(SAMPLE_MID_MAX);
  localparam logic [RUN_W-1:0]           LOW_MIN_R  = RUN_W'(SAMPLE_LOW_MIN);
  localparam logic [RUN_W-1:0]           RUN_SAT    = {RUN_W{1'b1}};
  localparam logic [GAP_W-1:0]           GAP_R      = GAP_W'(CLAPS_GAP_SAMPLES);
  localparam logic [CLAPS_OUT_WIDTH-1:0] MAX_R      = CLAPS_OUT_WIDTH'(MAX_CLAPS);

  typedef enum logic [1:0] {IDLE, HIGH, MID, LOW} state_t;

  state_t                     state, state_n;
  logic [RUN_W-1:0]           run, run_n, run_inc;
  logic [CLAPS_OUT_WIDTH-1:0] total, total_n;
  logic [GAP_W-1:0]           gap, gap_n;
  logic                       active, active_n;
  logic [CLAPS_OUT_WIDTH-1:0] data_n;
  logic                       full_n, valid_n;
  logic                       accept, cls_h, cls_l, to_low, clap, blank;

  assign energy_ready = !claps_out_valid;
  assign accept       = energy_valid && energy_ready;
  assign cls_h        = energy_data >= HIGH_T;
  assign cls_l        = energy_data < LOW_T;
  assign run_inc      = (run == RUN_SAT) ? run : run + 1'b1;

`ifdef CLAP_REFRACTORY_EN
  localparam int REFR_W = (REFRACTORY_SAMPLES > 0) ? $clog2(REFRACTORY_SAMPLES + 1) : 1;
  localparam logic [REFR_W-1:0] REFR_R = REFR_W'(REFRACTORY_SAMPLES);

  logic [REFR_W-1:0] refr;

  assign blank = refr != '0;

  // Blanking counter: loaded by the clap sample, counts down on later accepts.
  always_ff @(posedge clock or negedge counters_nreset) begin
    if (!counters_nreset) begin
      refr <= '0;
    end else if (accept) begin
      if (clap) begin
        refr <= REFR_R;
      end else if (blank) begin
        refr <= refr - 1'b1;
      end
    end
  end
`else
  // Blanking is compiled out; REFRACTORY_SAMPLES has no effect in this build.
  assign blank = 1'b0 && (REFRACTORY_SAMPLES != 0);
`endif

  always_ff @(posedge clock or negedge counters_nreset) begin
    if (!counters_nreset) begin
      state           <= IDLE;
      run             <= '0;
      total           <= '0;
      gap             <= '0;
      active          <= 1'b0;
      claps_out_data  <= '0;
      claps_out_full  <= 1'b0;
      claps_out_valid <= 1'b0;
    end else begin
      state           <= state_n;
      run             <= run_n;
      total           <= total_n;
      gap             <= gap_n;
      active          <= active_n;
      claps_out_data  <= data_n;
      claps_out_full  <= full_n;
      claps_out_valid <= valid_n;
    end
  end

  always_comb begin
    state_n  = state;
    run_n    = run;
    total_n  = total;
    gap_n    = gap;
    active_n = active;
    data_n   = claps_out_data;
    full_n   = claps_out_full;
    valid_n  = claps_out_valid;
    to_low   = 1'b0;
    clap     = 1'b0;

    if (claps_out_valid && claps_out_ready) begin
      valid_n = 1'b0;
    end

    // accept implies no result is pending, so an emit below never collides
    // with the handshake above.
    if (accept) begin
      if (blank) begin
        state_n = IDLE;
        run_n   = '0;
      end else begin
        case (state)
          IDLE: begin
            if (cls_h) begin
              state_n = HIGH;
              run_n   = RUN_W'(1);
            end
          end
          HIGH: begin
            if (cls_h) begin
              run_n = run_inc;
            end else if (run >= HIGH_MIN_R) begin
              if (cls_l) begin
                to_low = 1'b1;
              end else begin
                state_n = MID;
                run_n   = RUN_W'(1);
              end
            end else begin
              state_n = IDLE;
              run_n   = '0;
            end
          end
          MID: begin
            if (cls_l) begin
              to_low = 1'b1;
            end else if (cls_h || run >= MID_MAX_R) begin
              // run >= MID_MAX here means the incremented run would exceed it
              state_n = IDLE;
              run_n   = '0;
            end else begin
              run_n = run_inc;
            end
          end
          LOW: begin
            if (!cls_l) begin
              state_n = IDLE;
              run_n   = '0;
            end else if (run_inc >= LOW_MIN_R) begin
              clap    = 1'b1;
              state_n = IDLE;
              run_n   = '0;
            end else begin
              run_n = run_inc;
            end
          end
          default: begin
            state_n = IDLE;
            run_n   = '0;
          end
        endcase

        // The sample that enters LOW already counts toward SAMPLE_LOW_MIN.
        if (to_low) begin
          if (SAMPLE_LOW_MIN <= 1) begin
            clap    = 1'b1;
            state_n = IDLE;
            run_n   = '0;
          end else begin
            state_n = LOW;
            run_n   = RUN_W'(1);
          end
        end
      end

      if (clap) begin
        gap_n = '0;
        if (total + 1'b1 == MAX_R) begin
          data_n   = MAX_R;
          full_n   = 1'b1;
          valid_n  = 1'b1;
          total_n  = '0;
          active_n = 1'b0;
        end else begin
          total_n  = total + 1'b1;
          active_n = 1'b1;
        end
      end else if (active) begin
        if (gap + 1'b1 == GAP_R) begin
          data_n   = total;
          full_n   = 1'b0;
          valid_n  = 1'b1;
          total_n  = '0;
          gap_n    = '0;
          active_n = 1'b0;
        end else begin
          gap_n = gap + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_clap_sequence_detector.sv
// tb/tb_clap_sequence_detector.sv - directed bench for clap_sequence_detector
module tb_clap_sequence_detector;

  logic        clock = 1'b0;
  logic        counters_nreset = 1'b0;
  logic [15:0] energy_data = '0;
  logic        energy_valid = 1'b0;
  logic        energy_ready;
  logic [3:0]  claps_out_data;
  logic        claps_out_full;
  logic        claps_out_valid;
  logic        claps_out_ready = 1'b1;

  int passed = 0;
  int failed = 0;
  int total_checks = 0;
  int hs_count = 0;

  clap_sequence_detector #(
    .ENERGY_WIDTH(16),
    .ENERGY_HIGH_THRESHOLD(100),
    .ENERGY_LOW_THRESHOLD(50),
    .SAMPLE_HIGH_MIN(2),
    .SAMPLE_MID_MAX(3),
    .SAMPLE_LOW_MIN(4),
    .CLAPS_GAP_SAMPLES(10),
    .MAX_CLAPS(3),
    .CLAPS_OUT_WIDTH(4),
    .REFRACTORY_SAMPLES(5)
  ) dut (
    .clock(clock),
    .counters_nreset(counters_nreset),
    .energy_data(energy_data),
    .energy_valid(energy_valid),
    .energy_ready(energy_ready),
    .claps_out_data(claps_out_data),
    .claps_out_full(claps_out_full),
    .claps_out_valid(claps_out_valid),
    .claps_out_ready(claps_out_ready)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (claps_out_valid && claps_out_ready) hs_count++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    total_checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic put(input int v);
    energy_data  = 16'(v);
    energy_valid = 1'b1;
    @(posedge clock);
    #1;
    energy_valid = 1'b0;
  endtask

  task automatic put_n(input int v, input int n);
    for (int i = 0; i < n; i++) put(v);
  endtask

  task automatic put_env();
    put(120); put(120); put(60);
    put(10); put(10); put(10); put(10);
  endtask

  task automatic check_out(input string tag, input int v, input int d, input int f);
    check({tag, "_valid"}, int'(claps_out_valid), v);
    check({tag, "_data"}, int'(claps_out_data), d);
    check({tag, "_full"}, int'(claps_out_full), f);
    check({tag, "_eready"}, int'(energy_ready), v ? 0 : 1);
  endtask

  task automatic handshake(input string tag);
    @(posedge clock);
    #1;
    check({tag, "_hs_valid"}, int'(claps_out_valid), 0);
    check({tag, "_hs_eready"}, int'(energy_ready), 1);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check_out("reset", 0, 0, 0);
    counters_nreset = 1'b1;

    // Single clap: output exactly on the 10th gap sample
    put_env();
    put_n(10, 9);
    check("single_early_valid", int'(claps_out_valid), 0);
    put(10);
    check_out("single", 1, 1, 0);
    handshake("single");
    check("single_hs_count", hs_count, 1);

    // Short attack, then long decay: no clap in either
    put(120); put_n(10, 4);
    put_n(10, 12);
    put(120); put(120); put_n(60, 4);
    put_n(10, 16);
    check("noclap_valid", int'(claps_out_valid), 0);
    check("noclap_hs_count", hs_count, 1);

    // Forced emit at MAX_CLAPS without waiting for the gap
    put_env(); put_n(10, 2);
    put_env(); put_n(10, 2);
    put_env();
    check_out("forced", 1, 3, 1);
    handshake("forced");
    check("forced_hs_count", hs_count, 2);

    // Backpressure: result and energy_ready held while claps_out_ready=0
    claps_out_ready = 1'b0;
    put_env();
    put_n(10, 10);
    check_out("bp_first", 1, 1, 0);
    energy_data  = 16'd120;
    energy_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock);
      #1;
      check_out("bp_hold", 1, 1, 0);
    end
    claps_out_ready = 1'b1;
    energy_valid    = 1'b0;
    handshake("bp");
    check("bp_hs_count", hs_count, 3);
    // Frozen FSM: the held 120s were never accepted, so these tens stay idle
    put_n(10, 16);
    check("bp_frozen_valid", int'(claps_out_valid), 0);
    check("bp_frozen_hs_count", hs_count, 3);

    // Reset mid-sequence discards the open sequence
    put_env(); put_n(10, 3);
    #3;
    counters_nreset = 1'b0;
    #1;
    check_out("midreset", 0, 0, 0);
    @(posedge clock);
    #1;
    counters_nreset = 1'b1;
    put_n(10, 12);
    check("midreset_quiet_valid", int'(claps_out_valid), 0);
    check("midreset_hs_count", hs_count, 3);
    put_env();
    put_n(10, 10);
    check_out("after_reset", 1, 1, 0);
    handshake("after_reset");
    check("after_reset_hs_count", hs_count, 4);

`ifdef CLAP_REFRACTORY_EN
    // Second envelope starts inside the blanking window and is not counted
    put_env();
    put_n(10, 3);
    put_env();
    check_out("refr", 1, 1, 0);
    handshake("refr");
`endif

    $display("%0d/%0d checks passed", passed, total_checks);
    $finish;
  end

endmodule
